// File: rtl/data_sync_pkg.sv
// Shared types and constants for the multi-channel multi-cycle-path bus synchronizer.
package data_sync_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int MODE_LEVEL  = 0;
  localparam int MODE_TOGGLE = 1;

endpackage

// File: rtl/data_sync_mc_if.sv
// Bus bundle for data_sync_mc: source-side enables/data, consumer handshake and captured outputs.
interface data_sync_mc_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);

  logic [CHANNELS-1:0]       bus_enable;
  logic [CHANNELS*WIDTH-1:0] unsync_bus;
  logic [CHANNELS-1:0]       sync_ready;
  logic [CHANNELS-1:0]       overrun_clr;
  logic [CHANNELS*WIDTH-1:0] sync_bus;
  logic [CHANNELS-1:0]       sync_valid;
  logic [CHANNELS-1:0]       enable_pulse;
  logic [CHANNELS-1:0]       overrun;

  modport master (
    output bus_enable, unsync_bus, sync_ready, overrun_clr,
    input  sync_bus, sync_valid, enable_pulse, overrun
  );

  modport slave (
    input  bus_enable, unsync_bus, sync_ready, overrun_clr,
    output sync_bus, sync_valid, enable_pulse, overrun
  );

endinterface

// File: rtl/data_sync_chan.sv
// One synchronizer channel: enable sync chain, edge detect, valid/ready hold FSM and capture.
// Overrun detection with drop policy is built when DATA_SYNC_OVERRUN_EN is defined.
module data_sync_chan
  import data_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int TOGGLE_MODE = MODE_LEVEL
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             bus_enable,
  input  logic [WIDTH-1:0] unsync_bus,
  input  logic             sync_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] sync_bus,
  output logic             sync_valid,
  output logic             enable_pulse,
  output logic             overrun
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              s_d_q, s_d_d;
  logic              evt_s;
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sync_bus_q, sync_bus_d;
  logic              pulse_q, pulse_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], bus_enable};
    s_d_d  = sync_q[STAGES-1];
    if (TOGGLE_MODE == MODE_TOGGLE) begin
      evt_s = sync_q[STAGES-1] ^ s_d_q;
    end else begin
      evt_s = sync_q[STAGES-1] & ~s_d_q;
    end
  end

  // Drop policy only exists with overrun detection; otherwise the latest word always wins.
  always_comb begin
    state_d    = state_q;
    sync_bus_d = sync_bus_q;
    pulse_d    = 1'b0;
`ifdef DATA_SYNC_OVERRUN_EN
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
`else
    overrun_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (evt_s) begin
          sync_bus_d = unsync_bus;
          pulse_d    = 1'b1;
          state_d    = HOLD;
        end else begin
          state_d    = IDLE;
        end
      end
      HOLD: begin
        if (evt_s) begin
`ifdef DATA_SYNC_OVERRUN_EN
          if (sync_ready) begin
            sync_bus_d = unsync_bus;
            pulse_d    = 1'b1;
          end else begin
            overrun_d  = 1'b1;
          end
`else
          sync_bus_d = unsync_bus;
          pulse_d    = 1'b1;
`endif
          state_d = HOLD;
        end else if (sync_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q     <= {STAGES{1'b0}};
      s_d_q      <= 1'b0;
      state_q    <= IDLE;
      sync_bus_q <= {WIDTH{1'b0}};
      pulse_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      s_d_q      <= s_d_d;
      state_q    <= state_d;
      sync_bus_q <= sync_bus_d;
      pulse_q    <= pulse_d;
      overrun_q  <= overrun_d;
    end
  end

`ifndef DATA_SYNC_OVERRUN_EN
  logic overrun_clr_unused;
  assign overrun_clr_unused = overrun_clr;
`endif

  assign sync_bus     = sync_bus_q;
  assign sync_valid   = (state_q == HOLD);
  assign enable_pulse = pulse_q;
  assign overrun      = overrun_q;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel destination-domain bus synchronizer; one independent data_sync_chan per channel.
// Optional overrun detection: DATA_SYNC_OVERRUN_EN.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int CHANNELS    = 2,
  parameter int TOGGLE_MODE = MODE_LEVEL
) (
  input  logic         CLK,
  input  logic         RST,
  data_sync_mc_if.slave bus
);

  logic [CHANNELS*WIDTH-1:0] sync_bus_s;
  logic [CHANNELS-1:0]       sync_valid_s;
  logic [CHANNELS-1:0]       enable_pulse_s;
  logic [CHANNELS-1:0]       overrun_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    data_sync_chan #(
      .WIDTH       (WIDTH),
      .STAGES      (STAGES),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_chan (
      .CLK          (CLK),
      .RST          (RST),
      .bus_enable   (bus.bus_enable[i]),
      .unsync_bus   (bus.unsync_bus[i*WIDTH +: WIDTH]),
      .sync_ready   (bus.sync_ready[i]),
      .overrun_clr  (bus.overrun_clr[i]),
      .sync_bus     (sync_bus_s[i*WIDTH +: WIDTH]),
      .sync_valid   (sync_valid_s[i]),
      .enable_pulse (enable_pulse_s[i]),
      .overrun      (overrun_s[i])
    );
  end

  assign bus.sync_bus     = sync_bus_s;
  assign bus.sync_valid   = sync_valid_s;
  assign bus.enable_pulse = enable_pulse_s;
  assign bus.overrun      = overrun_s;

endmodule

// File: tb/tb_data_sync_mc.sv
// Bench for data_sync_mc: a 4-channel level-mode instance and a 2-channel toggle-mode instance,
// directed steps then random traffic, checked against a sample-history reference model.
module tb_data_sync_mc;

`ifdef DATA_SYNC_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif
  localparam int STG = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [3:0]  en_v[2], rdy_v[2], clr_v[2];
  logic [31:0] dat_v[2];
  logic [31:0] obus[2];
  logic [3:0]  oval[2], opul[2], oovr[2];

  data_sync_mc_if #(.WIDTH(8), .CHANNELS(4)) if_l ();
  data_sync_mc_if #(.WIDTH(8), .CHANNELS(2)) if_t ();

  data_sync_mc #(.WIDTH(8), .STAGES(STG), .CHANNELS(4), .TOGGLE_MODE(0)) dut_l (
    .CLK (clk), .RST (rst), .bus (if_l)
  );
  data_sync_mc #(.WIDTH(8), .STAGES(STG), .CHANNELS(2), .TOGGLE_MODE(1)) dut_t (
    .CLK (clk), .RST (rst), .bus (if_t)
  );

  assign if_l.bus_enable  = en_v[0];
  assign if_l.unsync_bus  = dat_v[0];
  assign if_l.sync_ready  = rdy_v[0];
  assign if_l.overrun_clr = clr_v[0];
  assign if_t.bus_enable  = en_v[1][1:0];
  assign if_t.unsync_bus  = dat_v[1][15:0];
  assign if_t.sync_ready  = rdy_v[1][1:0];
  assign if_t.overrun_clr = clr_v[1][1:0];
  assign obus[0] = if_l.sync_bus;
  assign oval[0] = if_l.sync_valid;
  assign opul[0] = if_l.enable_pulse;
  assign oovr[0] = if_l.overrun;
  assign obus[1] = {16'h0000, if_t.sync_bus};
  assign oval[1] = {2'b00, if_t.sync_valid};
  assign opul[1] = {2'b00, if_t.enable_pulse};
  assign oovr[1] = {2'b00, if_t.overrun};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: h[m][c][k] is the enable sampled k edges ago (k=0 is the current edge).
  bit       h[2][4][STG+2];
  bit       m_val[2][4], m_pul[2][4], m_ovr[2][4];
  bit [7:0] m_dat[2][4];

  function automatic int nch(input int m);
    return (m == 0) ? 4 : 2;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < STG + 2; k++) h[m][c][k] = 1'b0;
        m_val[m][c] = 1'b0; m_pul[m][c] = 1'b0; m_ovr[m][c] = 1'b0; m_dat[m][c] = 8'h00;
      end
  endtask

  // Predicts the effect of the coming rising edge from the inputs currently driven.
  task automatic model_edge();
    bit ev;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < nch(m); c++) begin
        for (int k = STG + 1; k > 0; k--) h[m][c][k] = h[m][c][k-1];
        h[m][c][0] = en_v[m][c];
        ev = (m == 0) ? (h[m][c][STG] && !h[m][c][STG+1]) : (h[m][c][STG] != h[m][c][STG+1]);
        m_pul[m][c] = 1'b0;
        if (OVR_EN && clr_v[m][c]) m_ovr[m][c] = 1'b0;
        if (ev) begin
          if (!m_val[m][c] || rdy_v[m][c] || !OVR_EN) begin
            m_dat[m][c] = dat_v[m][c*8 +: 8];
            m_pul[m][c] = 1'b1;
            m_val[m][c] = 1'b1;
          end else begin
            m_ovr[m][c] = 1'b1;
          end
        end else if (m_val[m][c] && rdy_v[m][c]) begin
          m_val[m][c] = 1'b0;
        end
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] eb;
    logic [3:0]  ev, ep, eo;
    for (int m = 0; m < 2; m++) begin
      eb = 32'h0; ev = 4'h0; ep = 4'h0; eo = 4'h0;
      for (int c = 0; c < nch(m); c++) begin
        eb[c*8 +: 8] = m_dat[m][c];
        ev[c] = m_val[m][c]; ep[c] = m_pul[m][c]; eo[c] = m_ovr[m][c];
      end
      chk($sformatf("m%0d_sync_bus", m), obus[m], eb);
      chk($sformatf("m%0d_sync_valid", m), {28'h0, oval[m]}, {28'h0, ev});
      chk($sformatf("m%0d_enable_pulse", m), {28'h0, opul[m]}, {28'h0, ep});
      chk($sformatf("m%0d_overrun", m), {28'h0, oovr[m]}, {28'h0, eo});
    end
  endtask

  task automatic cycle();
    if (rst) model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int m = 0; m < 2; m++) begin
      en_v[m] = 4'h0; rdy_v[m] = 4'h0; clr_v[m] = 4'h0; dat_v[m] = 32'h0;
    end
    rst = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Basic capture: latency STAGES+1, single-cycle pulse.
    dat_v[0][7:0] = 8'hA5; en_v[0][0] = 1'b1;
    cycles(2);
    chk("pre_capture_valid", {31'h0, oval[0][0]}, 32'h0);
    cycle();
    chk("cap_bus", {24'h0, obus[0][7:0]}, 32'h0000_00A5);
    chk("cap_pulse", {31'h0, opul[0][0]}, 32'h1);
    chk("cap_valid", {31'h0, oval[0][0]}, 32'h1);
    cycle();
    chk("pulse_low_after", {31'h0, opul[0][0]}, 32'h0);

    // Hold while not ready, release one edge after ready.
    cycles(4);
    chk("hold_valid", {31'h0, oval[0][0]}, 32'h1);
    chk("hold_bus", {24'h0, obus[0][7:0]}, 32'h0000_00A5);
    rdy_v[0][0] = 1'b1;
    cycle();
    chk("release_valid", {31'h0, oval[0][0]}, 32'h0);

    // Overrun: second word arrives while the first is still pending.
    rdy_v[0][0] = 1'b0; en_v[0][0] = 1'b0;
    cycles(3);
    dat_v[0][7:0] = 8'h11; en_v[0][0] = 1'b1;
    cycles(3);
    chk("ovr_first_bus", {24'h0, obus[0][7:0]}, 32'h0000_0011);
    en_v[0][0] = 1'b0;
    cycles(2);
    dat_v[0][7:0] = 8'h22; en_v[0][0] = 1'b1;
    cycles(3);
    if (OVR_EN) begin
      chk("ovr_bus_kept", {24'h0, obus[0][7:0]}, 32'h0000_0011);
      chk("ovr_no_pulse", {31'h0, opul[0][0]}, 32'h0);
      chk("ovr_set", {31'h0, oovr[0][0]}, 32'h1);
    end else begin
      chk("lw_bus_new", {24'h0, obus[0][7:0]}, 32'h0000_0022);
      chk("lw_pulse", {31'h0, opul[0][0]}, 32'h1);
      chk("lw_no_ovr", {31'h0, oovr[0][0]}, 32'h0);
    end
    clr_v[0][0] = 1'b1;
    cycle();
    clr_v[0][0] = 1'b0;
    chk("ovr_cleared", {31'h0, oovr[0][0]}, 32'h0);

    // Toggle mode: both edges of the enable are events.
    rdy_v[1][0] = 1'b1;
    dat_v[1][7:0] = 8'h01; en_v[1][0] = 1'b1;
    cycles(3);
    chk("tog_pulse1", {31'h0, opul[1][0]}, 32'h1);
    chk("tog_bus1", {24'h0, obus[1][7:0]}, 32'h0000_0001);
    dat_v[1][7:0] = 8'h02; en_v[1][0] = 1'b0;
    cycles(3);
    chk("tog_pulse2", {31'h0, opul[1][0]}, 32'h1);
    chk("tog_bus2", {24'h0, obus[1][7:0]}, 32'h0000_0002);

    // All four channels rise on the same edge.
    en_v[0] = 4'h0; rdy_v[0] = 4'hF;
    cycles(3);
    dat_v[0] = 32'h4030_2010; en_v[0] = 4'hF;
    cycles(3);
    chk("multi_bus", obus[0], 32'h4030_2010);
    chk("multi_pulse", {28'h0, opul[0]}, 32'h0000_000F);

    // Reset while HOLD with enables still high: fresh capture after release.
    rdy_v[0] = 4'h0;
    cycles(2);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", {28'h0, oval[0]}, 32'h0);
    chk("rst_bus", obus[0], 32'h0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    dat_v[0] = 32'h8877_6655;
    cycles(2);
    chk("rst_no_early_pulse", {28'h0, opul[0]}, 32'h0);
    cycle();
    chk("rst_recapture_pulse", {28'h0, opul[0]}, 32'h0000_000F);
    chk("rst_recapture_bus", obus[0], 32'h8877_6655);

    // Random traffic against the model.
    for (int it = 0; it < 400; it++) begin
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 3) == 0) begin
            en_v[m][c] = ~en_v[m][c];
            dat_v[m][c*8 +: 8] = 8'($urandom());
          end
          rdy_v[m][c] = ($urandom_range(0, 2) == 0);
          clr_v[m][c] = ($urandom_range(0, 7) == 0);
        end
      if (it == 200) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sync_mc.md
Name: data_sync_mc

Overview:
- Multi-channel, destination-domain bus synchronizer using the multi-cycle-path scheme.
- Each channel carries a bus that is stable while its enable is synchronized through a STAGES-deep flop chain; the synchronized enable event captures the bus.
- Adds over the single-channel synchronizer:
  - a valid/ready hold stage per channel;
  - a toggle-mode enable option;
  - sticky overrun detection when a new word arrives before the consumer has taken the previous one.
- Sits at the receive side of every slow-to-fast or unrelated-clock bus crossing in the system.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- STAGES, 2, synchronizer flop depth on each enable (>=2).
- CHANNELS, 2, number of independent channels (>=1).
- TOGGLE_MODE, 0, enable event definition:
  - 0 = rising edge of level enable;
  - 1 = any transition of enable.

Ports:
- CLK  in  1  destination clock.
- RST  in  1  reset, asynchronous, active-low.
- bus_enable  in  CHANNELS  unsynchronized per-channel enable (source domain).
- unsync_bus  in  CHANNELS*WIDTH  unsynchronized data; channel i at bits [i*WIDTH +: WIDTH]; must be stable from enable change until capture.
- sync_ready  in  CHANNELS  consumer ready per channel.
- overrun_clr  in  CHANNELS  synchronous clear of the sticky overrun flag.
- sync_bus  out  CHANNELS*WIDTH  captured data, registered.
- sync_valid  out  CHANNELS  captured word pending.
- enable_pulse  out  CHANNELS  one-cycle pulse coincident with each sync_bus update.
- overrun  out  CHANNELS  sticky: a word was dropped.

Behaviour:
- Reset (RST low, asynchronous): all synchronizer flops, edge flops, sync_bus, sync_valid, enable_pulse and overrun clear to 0. The FSM goes to IDLE.
- Per channel:
  - bus_enable passes through STAGES flops to give s.
  - An edge flop holds s_d (s delayed one cycle).
  - Event definition:
    - TOGGLE_MODE=0: evt = s & ~s_d.
    - TOGGLE_MODE=1: evt = s ^ s_d.
- Latency: bus_enable is first sampled high at edge 1. evt is asserted after edge STAGES. sync_bus, enable_pulse and sync_valid update at edge STAGES+1.
- FSM states:
  - IDLE (sync_valid=0).
  - HOLD (sync_valid=1).
- Transitions:
  - IDLE, evt:
    - capture bus into sync_bus;
    - pulse enable_pulse;
    - go to HOLD.
  - HOLD, sync_ready & ~evt: go to IDLE; sync_bus holds its value.
  - HOLD, evt & sync_ready: capture the new word, pulse enable_pulse, stay in HOLD. No overrun.
  - HOLD, evt & ~sync_ready: new word dropped. sync_bus is unchanged, no enable_pulse, overrun is set. Stays in HOLD.
  - HOLD, neither evt nor sync_ready: hold.
- overrun_clr clears overrun. If overrun_clr and a set condition occur in the same cycle, the set wins.
- Channels are fully independent; simultaneous events on all channels are all handled in the same cycle.
- Reset mid-operation: any pending word is discarded. Because the synchronizer is cleared, an enable still high after reset produces a fresh event (TOGGLE_MODE=0: rising edge seen from 0; TOGGLE_MODE=1: transition 0->1).
- sync_bus is never updated except on an accepted event. Consumers sample only while sync_valid is high.

Optional Feature:
- Macro: DATA_SYNC_OVERRUN_EN.
- Defined: overrun detection and drop policy as above.
- Undefined:
  - latest-wins policy: any evt captures and pulses regardless of sync_ready;
  - the FSM still tracks sync_valid;
  - overrun is tied to 0;
  - overrun_clr is ignored.

Decomposition:
- Package data_sync_pkg:
  - FSM state typedef (IDLE, HOLD);
  - TOGGLE_MODE encoding constants (MODE_LEVEL=0, MODE_TOGGLE=1).
- Sub-module data_sync_chan: one channel, containing the synchronizer chain, edge flop, FSM, capture register and overrun flag.
- The top level is a generate loop over CHANNELS plus bus slicing.

Test Plan:
- Basic capture:
  - Stimulus: STAGES=2, ch0 unsync_bus=0xA5, bus_enable 0->1 sampled at edge 1.
  - Response: sync_bus[7:0]=0xA5, enable_pulse=1 and sync_valid=1 at edge 3. Pulse is low at edge 4.
- Hold and handshake:
  - Stimulus: sync_ready=0 for 5 cycles after capture, then 1.
  - Response: sync_valid stays 1 with 0xA5; it drops one edge after ready.
- Overrun:
  - Stimulus: capture 0x11 with sync_ready=0; enable falls and rises again with 0x22.
  - Response: sync_bus stays 0x11, overrun=1, no second pulse.
  - Then pulse overrun_clr: overrun returns to 0.
  - With the macro undefined: sync_bus=0x22, a pulse occurs, overrun=0.
- Toggle mode:
  - Stimulus: TOGGLE_MODE=1, enable 0->1 (data 0x01), then 1->0 (data 0x02), ready held 1.
  - Response: two pulses, sync_bus 0x01 then 0x02.
- Multi-channel simultaneity:
  - Stimulus: CHANNELS=4, all enables rise on the same edge with data 0x10,0x20,0x30,0x40.
  - Response: all four captured and pulsed on the same edge, with correct slice mapping.
- Reset mid-HOLD:
  - Stimulus: assert RST low while sync_valid=1, with enable held high.
  - Response: outputs go to 0 immediately. After release, a recapture occurs at edge STAGES+1.
